// File: rtl/coalescing_store_buffer_if.sv
// Store-buffer bus bundle: committed-store port, load-forward probe,
// cache drain port and occupancy status.
interface coalescing_store_buffer_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [NB-1:0]     st_wmask;
    logic [DATA_W-1:0] st_wdata;
    logic              st_ready;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [NB-1:0]     ld_rmask;
    logic              fwd_hit;
    logic              fwd_full;
    logic [NB-1:0]     fwd_mask;
    logic [DATA_W-1:0] fwd_data;

    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic [NB-1:0]     dc_wmask;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_busy;
    logic              dc_resp;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output st_valid, st_addr, st_wmask, st_wdata,
        output ld_valid, ld_addr, ld_rmask,
        output dc_busy, dc_resp,
        input  st_ready, fwd_hit, fwd_full, fwd_mask, fwd_data,
        input  dc_req, dc_addr, dc_wmask, dc_wdata,
        input  count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_wmask, st_wdata,
        input  ld_valid, ld_addr, ld_rmask,
        input  dc_busy, dc_resp,
        output st_ready, fwd_hit, fwd_full, fwd_mask, fwd_data,
        output dc_req, dc_addr, dc_wmask, dc_wdata,
        output count, empty, full
    );
endinterface

// File: rtl/coalescing_store_buffer.sv
// Post-commit coalescing store buffer: circular queue of word entries with
// write merging, youngest-byte load forwarding and in-order single-request drain.
module coalescing_store_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    coalescing_store_buffer_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned WA_W  = ADDR_W - OFF;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_infl;
    logic [WA_W-1:0]   r_addr [DEPTH];
    logic [NB-1:0]     r_mask [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    state_t            r_state;

    state_t            w_state_nxt;
    logic              w_launch;
    logic              w_pop;
    logic              w_dc_req;
    logic [WA_W-1:0]   w_st_wa;
    logic [WA_W-1:0]   w_ld_wa;
    logic              w_match;
    logic [PTR_W-1:0]  w_match_idx;
    logic              w_st_fire;
    logic              w_push;
    logic              w_merge;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_st_bmask;
    logic [PTR_W-1:0]  w_fwd_idx;
    logic [NB-1:0]     w_fmask;
    logic [DATA_W-1:0] w_fdata;
    logic [NB-1:0]     w_fmask_r;
    logic [DATA_W-1:0] w_fbmask;
    logic              w_unused_ok;

    assign w_st_wa     = bus.st_addr[ADDR_W-1:OFF];
    assign w_ld_wa     = bus.ld_addr[ADDR_W-1:OFF];
    assign w_unused_ok = ^{bus.st_addr[OFF-1:0], bus.ld_addr[OFF-1:0]};

    // Drain FSM: launch head from IDLE, hold request until the cache responds
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_pop       = 1'b0;
        w_dc_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !bus.dc_busy) begin
                    w_launch    = 1'b1;
                    w_dc_req    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_dc_req = 1'b1;
                if (bus.dc_resp) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A head that is launching this cycle is already owned by the drain
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_infl[i] && (r_addr[i] == w_st_wa) &&
                !(w_launch && (PTR_W'(i) == r_head))) begin
                w_match     = 1'b1;
                w_match_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_st_bmask = '0;
        for (int b = 0; b < NB; b++) begin
            w_st_bmask[b*8 +: 8] = {8{bus.st_wmask[b]}};
        end
    end

    assign bus.st_ready = !r_full || w_match;
    assign w_st_fire    = bus.st_valid && bus.st_ready && (|bus.st_wmask);
    assign w_push       = w_st_fire && !w_match;
    assign w_merge      = w_st_fire && w_match;
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Walk oldest to youngest so younger bytes overwrite older ones
    always_comb begin
        w_fmask   = '0;
        w_fdata   = '0;
        w_fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_head + PTR_W'(i);
            if (r_valid[w_fwd_idx] && (r_addr[w_fwd_idx] == w_ld_wa)) begin
                for (int b = 0; b < NB; b++) begin
                    if (r_mask[w_fwd_idx][b]) begin
                        w_fmask[b]         = 1'b1;
                        w_fdata[b*8 +: 8]  = r_data[w_fwd_idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_fmask_r = w_fmask & bus.ld_rmask;
        w_fbmask  = '0;
        for (int b = 0; b < NB; b++) begin
            w_fbmask[b*8 +: 8] = {8{w_fmask_r[b]}};
        end
    end

    assign bus.fwd_mask = bus.ld_valid ? w_fmask_r : '0;
    assign bus.fwd_data = bus.ld_valid ? (w_fdata & w_fbmask) : '0;
    assign bus.fwd_hit  = bus.ld_valid && (|w_fmask_r);
    assign bus.fwd_full = bus.ld_valid && (|bus.ld_rmask) && (w_fmask_r == bus.ld_rmask);

    assign bus.dc_req   = w_dc_req;
    assign bus.dc_addr  = {r_addr[r_head], {OFF{1'b0}}};
    assign bus.dc_wmask = r_mask[r_head];
    assign bus.dc_wdata = r_data[r_head];

    assign bus.count = r_count;
    assign bus.empty = r_empty;
    assign bus.full  = r_full;

    // Control state: entry flags, pointers, occupancy and FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_infl  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_infl[r_head] <= 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_infl[r_head]  <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_infl[r_tail]  <= 1'b0;
                r_tail          <= r_tail + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    // Entry payload; disabled lanes are stored as zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= w_st_wa;
            r_mask[r_tail] <= bus.st_wmask;
            r_data[r_tail] <= bus.st_wdata & w_st_bmask;
        end
        if (w_merge) begin
            r_mask[w_match_idx] <= r_mask[w_match_idx] | bus.st_wmask;
            r_data[w_match_idx] <= (r_data[w_match_idx] & ~w_st_bmask) |
                                   (bus.st_wdata & w_st_bmask);
        end
    end
endmodule
